// File: rtl/debounce_bank.sv
// debounce_bank: bank of CHANNELS independent button debouncers sharing one
// tick prescaler. Each channel gives a debounced level, press/release pulses,
// a long-press pulse and (optionally) an auto-repeat pulse.
// Build option: define DEBOUNCE_REPEAT_EN to include the auto-repeat timers;
// without it repeat_p is tied low.
module debounce_bank #(
   parameter int CHANNELS     = 4,
   parameter int TICK_DIV     = 1000,
   parameter int STABLE_TICKS = 10,
   parameter int LONG_TICKS   = 500,
   parameter int REPEAT_TICKS = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn,
   output logic [CHANNELS-1:0] state,
   output logic [CHANNELS-1:0] pressed,
   output logic [CHANNELS-1:0] released,
   output logic [CHANNELS-1:0] long_press,
   output logic [CHANNELS-1:0] repeat_p
);

   localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
   localparam int HOLD_W = $clog2(LONG_TICKS + 1);

   if (CHANNELS < 1 || TICK_DIV < 1 || STABLE_TICKS < 1 ||
       LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
      $error("debounce_bank: all parameters must be >= 1");
   end

   logic [CHANNELS-1:0] sync_q1;
   logic [CHANNELS-1:0] sync_q2;
   logic [DIV_W-1:0]    div_cnt;
   logic                tick;

   // two-flop synchronizer on the raw button levels
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
      end
   end

   assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

   // shared prescaler, tick on the last count of each period
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_W-1:0]  cnt;
      logic [HOLD_W-1:0] hold;
      logic              st_q;
      logic              pr_q;
      logic              rl_q;
      logic              lp_q;
      logic              rp_q;
      logic              flip;
      logic              fall;
      logic              hold_full;

      // flip happens on the STABLE_TICKS-th consecutive disagreeing tick
      assign flip      = tick && (sync_q2[i] != st_q) &&
                         (cnt == CNT_W'(STABLE_TICKS - 1));
      assign fall      = flip && st_q;
      assign hold_full = (hold == HOLD_W'(LONG_TICKS));

      // stability counter, debounced level and edge pulses
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt  <= '0;
            st_q <= 1'b0;
            pr_q <= 1'b0;
            rl_q <= 1'b0;
         end else begin
            pr_q <= 1'b0;
            rl_q <= 1'b0;
            if (sync_q2[i] == st_q) begin
               cnt <= '0;
            end else if (flip) begin
               cnt  <= '0;
               st_q <= sync_q2[i];
               pr_q <= sync_q2[i];
               rl_q <= ~sync_q2[i];
            end else if (tick) begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      // hold timer; long press is dropped if release lands on the same tick
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            hold <= '0;
            lp_q <= 1'b0;
         end else begin
            lp_q <= st_q && tick && !fall && (hold == HOLD_W'(LONG_TICKS - 1));
            if (!st_q) begin
               hold <= '0;
            end else if (tick && !hold_full) begin
               hold <= hold + 1'b1;
            end
         end
      end

`ifdef DEBOUNCE_REPEAT_EN
      localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
      logic [RPT_W-1:0] rpt;

      // repeat timer runs only once the hold timer has saturated
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rpt  <= '0;
            rp_q <= 1'b0;
         end else begin
            rp_q <= 1'b0;
            if (!st_q) begin
               rpt <= '0;
            end else if (tick && hold_full) begin
               if (rpt == RPT_W'(REPEAT_TICKS - 1)) begin
                  rpt  <= '0;
                  rp_q <= !fall;
               end else begin
                  rpt <= rpt + 1'b1;
               end
            end
         end
      end
`else
      assign rp_q = 1'b0;
`endif

      assign state[i]      = st_q;
      assign pressed[i]    = pr_q;
      assign released[i]   = rl_q;
      assign long_press[i] = lp_q;
      assign repeat_p[i]   = rp_q;
   end

endmodule
